cc_pattern_driver: RTL and testbench

CC_PATTERN_DRIVER -- requirements
Module: cc_pattern_driver

---
 rtl/cc_pkg.sv | 38 +++
 rtl/cc_pattern_driver_if.sv | 24 ++
 rtl/cc_monitor.sv | 44 ++++
 rtl/cc_pattern_driver.sv | 168 ++++++++++++++++
 tb/tb_cc_pattern_driver.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cc_pkg.sv
// Shared constants for the CC pattern driver: pattern layout, phase lengths,
// response timeout and the sequencer state encoding.
package cc_pkg;

  localparam int PAT_W    = 223;
  localparam int SCORE_W  = 7;
  localparam int CNT_W    = 10;

  // MSB of each packed field; every field is stored MSB-first
  localparam int COLOR_HI = 222;
  localparam int SROW_HI  = 114;
  localparam int SCOL_HI  = 102;
  localparam int STYPE_HI = 90;
  localparam int AROW_HI  = 86;
  localparam int ACOL_HI  = 56;
  localparam int ACT_HI   = 26;
  localparam int SCORE_HI = 6;

  localparam int N_COLOR  = 36;
  localparam int N_STRIPE = 4;
  localparam int N_GAP    = 2;
  localparam int N_ACTION = 10;
  localparam int TIMEOUT  = 500;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEND1 = 3'd1,
    GAP   = 3'd2,
    SEND2 = 3'd3,
    WAIT  = 3'd4
  } state_t;

  // MSB position of element idx of a field that starts at bit hi with the given stride
  function automatic logic [7:0] field_msb(input int hi, input int step, input logic [5:0] idx);
    return 8'(hi - step * int'(idx));
  endfunction

endpackage

// File: rtl/cc_pattern_driver_if.sv
// Link between the pattern driver and the CC game block.
// Handshake: each in_* data field is qualified by its valid (in_valid_1 for
// colour/stripe, in_valid_2 for action) and is forced to 0 when that valid is
// low; there is no ready. out_score is qualified by out_valid, must be 0 otherwise.
interface cc_pattern_driver_if;
  logic       in_valid_1;
  logic       in_valid_2;
  logic [2:0] in_color;
  logic [5:0] in_starting_pos;
  logic       in_stripe;
  logic [1:0] in_action;
  logic       out_valid;
  logic [6:0] out_score;

  modport master (
    output in_valid_1, in_valid_2, in_color, in_starting_pos, in_stripe, in_action,
    input  out_valid, out_score
  );

  modport slave (
    input  in_valid_1, in_valid_2, in_color, in_starting_pos, in_stripe, in_action,
    output out_valid, out_score
  );
endinterface

// File: rtl/cc_monitor.sv
// Sticky protocol checks on the game block's response channel.
module cc_monitor
  import cc_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               out_valid,
  input  logic [SCORE_W-1:0] out_score,
  input  logic [SCORE_W-1:0] exp_score,
  input  logic               busy,
  input  logic               in_wait,
  output logic               flag_reset,
  output logic               flag_valid,
  output logic               flag_score,
  output logic               flag_leak
);

  logic first_q;
  logic prev_valid_q;

  // first_q is high only for the first clock after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q      <= 1'b1;
      prev_valid_q <= 1'b0;
      flag_reset   <= 1'b0;
      flag_valid   <= 1'b0;
      flag_score   <= 1'b0;
      flag_leak    <= 1'b0;
    end else begin
      first_q      <= 1'b0;
      prev_valid_q <= out_valid;
      if (first_q && (out_valid || out_score != '0))
        flag_reset <= 1'b1;
      if (out_valid && (prev_valid_q || !in_wait))
        flag_valid <= 1'b1;
      if (out_valid && out_score != exp_score)
        flag_score <= 1'b1;
      if (busy && !out_valid && out_score != '0)
        flag_leak  <= 1'b1;
    end
  end

endmodule

// File: rtl/cc_pattern_driver.sv
// Serialises one 223-bit pattern into the CC game block, waits for its score
// and reports pass/fail; protocol violations are collected by cc_monitor.
module cc_pattern_driver
  import cc_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [PAT_W-1:0]    pat_data,
  cc_pattern_driver_if.master cc,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [4:0]          fail_flags,
  output logic [CNT_W-1:0]    pass_count,
  output state_t              dbg_state
);

  state_t             state_q, state_n;
  logic [5:0]         cyc_q, cyc_n;
  logic [CNT_W-1:0]   wcnt_q, wcnt_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [PAT_W-1:0]   pat_q, pat_n;
  logic               done_n, pass_n;
  logic               timeout_q, timeout_n;
  logic               armed_q;
  logic               score_match;

  logic               v1, v2, stripe;
  logic [2:0]         color;
  logic [5:0]         pos;
  logic [1:0]         action;

  logic mon_reset, mon_valid, mon_score, mon_leak;

  assign score_match = (cc.out_score == pat_q[SCORE_HI:0]);

  always_comb begin
    state_n   = state_q;
    cyc_n     = cyc_q;
    wcnt_n    = wcnt_q;
    cnt_n     = cnt_q;
    pat_n     = pat_q;
    done_n    = 1'b0;
    pass_n    = 1'b0;
    timeout_n = timeout_q;
    v1        = 1'b0;
    v2        = 1'b0;
    color     = '0;
    pos       = '0;
    stripe    = 1'b0;
    action    = '0;
    case (state_q)
      IDLE: begin
        // armed_q blocks a start sampled on the first edge after reset release
        if (start && armed_q) begin
          pat_n   = pat_data;
          cyc_n   = '0;
          state_n = SEND1;
        end
      end
      SEND1: begin
        v1    = 1'b1;
        color = pat_q[field_msb(COLOR_HI, 3, cyc_q) -: 3];
        if (cyc_q < 6'(N_STRIPE)) begin
          pos    = {pat_q[field_msb(SROW_HI, 3, cyc_q) -: 3],
                    pat_q[field_msb(SCOL_HI, 3, cyc_q) -: 3]};
          stripe = pat_q[field_msb(STYPE_HI, 1, cyc_q)];
        end
        if (cyc_q == 6'(N_COLOR - 1)) begin
          cyc_n   = '0;
          state_n = GAP;
        end else begin
          cyc_n = cyc_q + 6'd1;
        end
      end
      GAP: begin
        if (cyc_q == 6'(N_GAP - 1)) begin
          cyc_n   = '0;
          state_n = SEND2;
        end else begin
          cyc_n = cyc_q + 6'd1;
        end
      end
      SEND2: begin
        v2     = 1'b1;
        pos    = {pat_q[field_msb(AROW_HI, 3, cyc_q) -: 3],
                  pat_q[field_msb(ACOL_HI, 3, cyc_q) -: 3]};
        action = pat_q[field_msb(ACT_HI, 2, cyc_q) -: 2];
        if (cyc_q == 6'(N_ACTION - 1)) begin
          cyc_n   = '0;
          wcnt_n  = '0;
          state_n = WAIT;
        end else begin
          cyc_n = cyc_q + 6'd1;
        end
      end
      WAIT: begin
        if (cc.out_valid) begin
          done_n  = 1'b1;
          pass_n  = score_match;
          if (score_match && cnt_q != {CNT_W{1'b1}})
            cnt_n = cnt_q + 1'b1;
          state_n = IDLE;
        end else if (wcnt_q == CNT_W'(TIMEOUT - 1)) begin
          // this silent cycle is the 500th one spent waiting
          done_n    = 1'b1;
          timeout_n = 1'b1;
          state_n   = IDLE;
        end else begin
          wcnt_n = wcnt_q + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cyc_q     <= '0;
      wcnt_q    <= '0;
      cnt_q     <= '0;
      pat_q     <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_n;
      cyc_q     <= cyc_n;
      wcnt_q    <= wcnt_n;
      cnt_q     <= cnt_n;
      pat_q     <= pat_n;
      done      <= done_n;
      pass      <= pass_n;
      timeout_q <= timeout_n;
      armed_q   <= 1'b1;
    end
  end

  cc_monitor u_monitor (
    .clk        (clk),
    .rst_n      (rst_n),
    .out_valid  (cc.out_valid),
    .out_score  (cc.out_score),
    .exp_score  (pat_q[SCORE_HI:0]),
    .busy       (busy),
    .in_wait    (state_q == WAIT),
    .flag_reset (mon_reset),
    .flag_valid (mon_valid),
    .flag_score (mon_score),
    .flag_leak  (mon_leak)
  );

  assign cc.in_valid_1      = v1;
  assign cc.in_valid_2      = v2;
  assign cc.in_color        = color;
  assign cc.in_starting_pos = pos;
  assign cc.in_stripe       = stripe;
  assign cc.in_action       = action;

  assign busy       = (state_q != IDLE);
  assign fail_flags = {mon_leak, mon_score, timeout_q, mon_valid, mon_reset};
  assign pass_count = cnt_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_cc_pattern_driver.sv
// Bench for cc_pattern_driver: table of pattern/response cases with a stream
// scoreboard, a behavioural game responder and hand-written reset sequences.
module tb_cc_pattern_driver;
  import cc_pkg::*;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [PAT_W-1:0] pat_data = '0;
  logic             busy, done, pass;
  logic [4:0]       fail_flags;
  logic [9:0]       pass_count;
  state_t           dbg_state;

  cc_pattern_driver_if cc();

  cc_pattern_driver dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pat_data   (pat_data),
    .cc         (cc),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail_flags (fail_flags),
    .pass_count (pass_count),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit         cyclic;
    logic [6:0] exp_score;
    logic [6:0] resp_score;
    int         resp_delay;   // -1: responder stays silent
    int         resp_hold;
    bit         leak;
    bit         poke;
    logic       exp_pass;
    logic [9:0] exp_cnt;
    logic [4:0] exp_flags;
  } vec_t;

  vec_t tbl[7];

  // pattern fields, kept as separate arrays and packed MSB-first
  logic [2:0] f_color[N_COLOR];
  logic [2:0] f_srow[N_STRIPE];
  logic [2:0] f_scol[N_STRIPE];
  logic       f_stype[N_STRIPE];
  logic [2:0] f_arow[N_ACTION];
  logic [2:0] f_acol[N_ACTION];
  logic [1:0] f_act[N_ACTION];
  logic [6:0] f_score;

  logic [13:0] exp_q[$];
  logic [15:0] res_q[$];

  task automatic fill_fields(input bit cyclic, input logic [6:0] sc);
    for (int i = 0; i < N_COLOR; i++)
      f_color[i] = cyclic ? 3'(i % 6) : 3'($urandom_range(0, 7));
    for (int k = 0; k < N_STRIPE; k++) begin
      f_srow[k]  = cyclic ? 3'(k) : 3'($urandom_range(0, 7));
      f_scol[k]  = cyclic ? 3'(k) : 3'($urandom_range(0, 7));
      f_stype[k] = cyclic ? ((k % 2) == 0) : 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < N_ACTION; i++) begin
      f_arow[i] = 3'($urandom_range(0, 7));
      f_acol[i] = 3'($urandom_range(0, 7));
      f_act[i]  = 2'($urandom_range(0, 3));
    end
    f_score = sc;
  endtask

  function automatic logic [PAT_W-1:0] pack_pat();
    logic [PAT_W-1:0] p;
    p = '0;
    for (int i = 0; i < N_COLOR; i++)  p = {p[PAT_W-4:0], f_color[i]};
    for (int k = 0; k < N_STRIPE; k++) p = {p[PAT_W-4:0], f_srow[k]};
    for (int k = 0; k < N_STRIPE; k++) p = {p[PAT_W-4:0], f_scol[k]};
    for (int k = 0; k < N_STRIPE; k++) p = {p[PAT_W-2:0], f_stype[k]};
    for (int i = 0; i < N_ACTION; i++) p = {p[PAT_W-4:0], f_arow[i]};
    for (int i = 0; i < N_ACTION; i++) p = {p[PAT_W-4:0], f_acol[i]};
    for (int i = 0; i < N_ACTION; i++) p = {p[PAT_W-3:0], f_act[i]};
    p = {p[PAT_W-8:0], f_score};
    return p;
  endfunction

  // expected word per valid cycle: {v1, v2, color, pos, stripe, action}
  task automatic push_stream();
    logic [13:0] w;
    for (int i = 0; i < N_COLOR; i++) begin
      if (i < N_STRIPE) w = {1'b1, 1'b0, f_color[i], f_srow[i], f_scol[i], f_stype[i], 2'b00};
      else              w = {1'b1, 1'b0, f_color[i], 6'd0, 1'b0, 2'b00};
      exp_q.push_back(w);
    end
    for (int i = 0; i < N_ACTION; i++)
      exp_q.push_back({1'b0, 1'b1, 3'd0, f_arow[i], f_acol[i], 1'b0, f_act[i]});
  endtask

  // ---------------- stream scoreboard ----------------
  int cyc_n = 0, last_v1 = 0, first_v2 = 0, dones = 0;
  bit prev_v2_chk = 1'b0;

  always @(negedge clk) begin
    logic [13:0] got;
    cyc_n++;
    if (rst_n) begin
      got = {cc.in_valid_1, cc.in_valid_2, cc.in_color, cc.in_starting_pos, cc.in_stripe, cc.in_action};
      if (done) dones++;
      if (cc.in_valid_1) last_v1 = cyc_n;
      if (cc.in_valid_2 && !prev_v2_chk) first_v2 = cyc_n;
      if (cc.in_valid_1 || cc.in_valid_2) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL stream_extra: got %0h want no valid", got);
        end else begin
          check("stream_word", got, exp_q.pop_front());
        end
      end else begin
        check("idle_zero", got, 14'd0);
      end
    end
    prev_v2_chk = cc.in_valid_2;
  end

  // ---------------- game responder ----------------
  bit         resp_en = 1'b0, resp_drive = 1'b1, resp_leak = 1'b0;
  bit         man_valid = 1'b0;
  logic [6:0] resp_score = '0;
  int         resp_delay = 0, resp_hold = 1;
  bit         in_wait = 1'b0, prev_v2_r = 1'b0;
  int         wait_n = 0, hold_left = 0, done_wait_n = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_wait   = 1'b0;
      hold_left = 0;
      prev_v2_r = 1'b0;
    end else begin
      if (prev_v2_r && !cc.in_valid_2) begin
        in_wait = 1'b1;
        wait_n  = 0;
      end else if (in_wait) begin
        wait_n++;
      end
      if (hold_left > 0) hold_left--;
      if (in_wait && resp_en && wait_n == resp_delay) hold_left = resp_hold;
      if (done && in_wait) begin
        in_wait     = 1'b0;
        done_wait_n = wait_n;
      end
      prev_v2_r = cc.in_valid_2;
    end
    if (resp_drive) begin
      cc.out_valid = (hold_left > 0);
      if (hold_left > 0)                          cc.out_score = resp_score;
      else if (resp_leak && in_wait && wait_n == 0) cc.out_score = 7'd3;
      else                                        cc.out_score = 7'd0;
    end else begin
      cc.out_valid = man_valid;
      cc.out_score = 7'd0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_case(input vec_t v);
    logic [PAT_W-1:0] pat;
    logic [15:0]      r;
    int               n, d0;
    bit               got;
    fill_fields(v.cyclic, v.exp_score);
    pat = pack_pat();
    push_stream();
    res_q.push_back({v.exp_pass, v.exp_cnt, v.exp_flags});
    resp_en    = (v.resp_delay >= 0);
    resp_delay = v.resp_delay;
    resp_hold  = v.resp_hold;
    resp_score = v.resp_score;
    resp_leak  = v.leak;
    d0 = dones;
    @(negedge clk);
    start    = 1'b1;
    pat_data = pat;
    n   = 0;
    got = 1'b0;
    while (!got && n < 1500) begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
      if (v.poke && n == 10) begin
        start    = 1'b1;
        pat_data = ~pat;
      end
      if (v.poke && n == 11) start = 1'b0;
      if (done) got = 1'b1;
    end
    r = res_q.pop_front();
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done want done within 1500 cycles");
      exp_q.delete();
    end else begin
      check("pass", pass, r[15]);
      check("pass_count", pass_count, r[14:5]);
      check("stream_left", exp_q.size(), 0);
      check("gap_cycles", first_v2 - last_v1, 3);
    end
    @(negedge clk);
    check("done_pulse", done, 1'b0);
    check("busy_after_done", busy, 1'b0);
    check("fail_flags", fail_flags, r[4:0]);
    if (v.resp_delay < 0) check("timeout_cycles", done_wait_n, TIMEOUT);
    resp_en   = 1'b0;
    resp_leak = 1'b0;
    repeat (60) @(negedge clk);
    check("done_count", dones - d0, 1);
    check("idle_after", busy, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_pass"}, pass, 1'b0);
    check({tag, "_flags"}, fail_flags, 5'd0);
    check({tag, "_count"}, pass_count, 10'd0);
    check({tag, "_state"}, dbg_state, IDLE);
    check({tag, "_cc"}, {cc.in_valid_1, cc.in_valid_2, cc.in_color, cc.in_starting_pos,
                         cc.in_stripe, cc.in_action}, 14'd0);
  endtask

  task automatic reset_mid_send2();
    logic [PAT_W-1:0] pat;
    int n, cnt2;
    fill_fields(1'b0, 7'd33);
    pat = pack_pat();
    push_stream();
    resp_en = 1'b0;
    @(negedge clk);
    start    = 1'b1;
    pat_data = pat;
    n    = 0;
    cnt2 = 0;
    while (cnt2 < 6 && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
      if (cc.in_valid_2) cnt2++;
    end
    check("reached_send2_c5", cnt2, 6);
    // pass_count and flags are non-zero here from the earlier cases
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    exp_q.delete();
    @(negedge clk);
    resp_drive = 1'b0;
    man_valid  = 1'b1;
    @(negedge clk);
    // release with out_valid already high and a start in the same cycle
    rst_n    = 1'b1;
    start    = 1'b1;
    pat_data = pat;
    @(negedge clk);
    start     = 1'b0;
    man_valid = 1'b0;
    check("start_at_release_ignored", busy, 1'b0);
    check("flags_after_release", fail_flags, 5'b00011);
    repeat (2) @(negedge clk);
    resp_drive = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("rst_again");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("flags_clean", fail_flags, 5'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    tbl[0] = '{cyclic:1, exp_score:12,  resp_score:12,  resp_delay:3,  resp_hold:1, leak:0, poke:0,
               exp_pass:1, exp_cnt:1, exp_flags:5'b00000};
    tbl[1] = '{cyclic:0, exp_score:45,  resp_score:45,  resp_delay:0,  resp_hold:1, leak:0, poke:1,
               exp_pass:1, exp_cnt:2, exp_flags:5'b00000};
    tbl[2] = '{cyclic:0, exp_score:12,  resp_score:11,  resp_delay:1,  resp_hold:1, leak:0, poke:0,
               exp_pass:0, exp_cnt:2, exp_flags:5'b01000};
    tbl[3] = '{cyclic:0, exp_score:99,  resp_score:0,   resp_delay:-1, resp_hold:1, leak:0, poke:0,
               exp_pass:0, exp_cnt:2, exp_flags:5'b01100};
    tbl[4] = '{cyclic:0, exp_score:7,   resp_score:7,   resp_delay:2,  resp_hold:2, leak:0, poke:0,
               exp_pass:1, exp_cnt:3, exp_flags:5'b01110};
    tbl[5] = '{cyclic:0, exp_score:100, resp_score:100, resp_delay:4,  resp_hold:1, leak:1, poke:0,
               exp_pass:1, exp_cnt:4, exp_flags:5'b11110};
    tbl[6] = '{cyclic:0, exp_score:60,  resp_score:60,  resp_delay:1,  resp_hold:1, leak:0, poke:0,
               exp_pass:1, exp_cnt:1, exp_flags:5'b00000};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("in_reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("after_reset");

    for (int i = 0; i < 6; i++) run_case(tbl[i]);
    reset_mid_send2();
    run_case(tbl[6]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: got no finish want finish before 500000ns");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
